// File: rtl/cricket_pkg.sv
// Shared types and constants for the cricket ball-outcome path.
// This covers the outcome kinds, the nibble ranges that select them, and the LFSR defaults.
package cricket_pkg;

  typedef enum logic [3:0] {
    DOT, SINGLE, DOUBLE, TRIPLE, FOUR, SIX, WIDE, NOBALL, WICKET
  } outcome_kind_e;

  typedef enum logic [1:0] {
    IDLE, OFFER, COOLDOWN
  } state_e;

  typedef struct packed {
    logic [2:0] runs;
    logic       is_extra;
    logic       is_wicket;
    logic       legal_ball;
  } ball_t;

  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
  localparam logic [15:0] POLY_DEFAULT = 16'hB400;

  localparam logic [3:0] NIB_DOT_MAX    = 4'd2;
  localparam logic [3:0] NIB_SINGLE_MAX = 4'd6;
  localparam logic [3:0] NIB_DOUBLE_MAX = 4'd9;
  localparam logic [3:0] NIB_TRIPLE     = 4'd10;
  localparam logic [3:0] NIB_FOUR       = 4'd11;
  localparam logic [3:0] NIB_SIX        = 4'd12;
  localparam logic [3:0] NIB_WIDE       = 4'd13;
  localparam logic [3:0] NIB_NOBALL     = 4'd14;

  function automatic outcome_kind_e kind_of(input logic [3:0] nib);
    if (nib <= NIB_DOT_MAX)         return DOT;
    else if (nib <= NIB_SINGLE_MAX) return SINGLE;
    else if (nib <= NIB_DOUBLE_MAX) return DOUBLE;
    else if (nib == NIB_TRIPLE)     return TRIPLE;
    else if (nib == NIB_FOUR)       return FOUR;
    else if (nib == NIB_SIX)        return SIX;
    else if (nib == NIB_WIDE)       return WIDE;
    else if (nib == NIB_NOBALL)     return NOBALL;
    else                            return WICKET;
  endfunction

  function automatic ball_t decode(input outcome_kind_e k);
    ball_t b;
    b = '{runs: 3'd0, is_extra: 1'b0, is_wicket: 1'b0, legal_ball: 1'b1};
    case (k)
      SINGLE:  b.runs = 3'd1;
      DOUBLE:  b.runs = 3'd2;
      TRIPLE:  b.runs = 3'd3;
      FOUR:    b.runs = 3'd4;
      SIX:     b.runs = 3'd6;
      WIDE, NOBALL: begin
        b.runs       = 3'd1;
        b.is_extra   = 1'b1;
        b.legal_ball = 1'b0;
      end
      WICKET:  b.is_wicket = 1'b1;
      default: b.runs = 3'd0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/cg_lfsr16.sv
// Free-running 16-bit Galois LFSR. It runs from the same clock as the rest of the block.
// An all-zero seed is replaced by 1 so that the register never locks up.
module cg_lfsr16
  import cricket_pkg::*;
#(
  parameter logic [15:0] SEED = SEED_DEFAULT,
  parameter logic [15:0] POLY = POLY_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [15:0] o_state
);

  localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] r_state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= SEED_NZ;
    else       r_state <= (r_state >> 1) ^ (r_state[0] ? POLY : 16'h0000);
  end

  assign o_state = r_state;

endmodule

// File: rtl/delivery_outcome_gen.sv
// Turns one bowl-button press into one decoded ball result, offered on valid/ready.
// After each handshake, a cooldown period blocks further presses.
module delivery_outcome_gen
  import cricket_pkg::*;
#(
  parameter logic [15:0] SEED            = SEED_DEFAULT,
  parameter logic [15:0] POLY            = POLY_DEFAULT,
  parameter int          COOLDOWN_CYCLES = 4
) (
  input  logic        clk_fpga,
  input  logic        reset,
  input  logic        delivery,
  input  logic        enable,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [3:0]  outcome_code,
  output logic [2:0]  runs,
  output logic        is_extra,
  output logic        is_wicket,
  output logic        legal_ball,
  output logic [15:0] delivery_count,
  output logic [15:0] lfsr_state
);

  logic [15:0] w_lfsr;
  logic        r_sync1, r_sync2, r_prev;
  logic        w_press, w_load, w_hs;
  state_e      r_state, w_next;
  logic [7:0]  r_cool;
  ball_t       w_ball;
  logic        r_valid;
  logic [3:0]  r_code;
  ball_t       r_ball;
  logic [15:0] r_count;

  cg_lfsr16 #(.SEED(SEED), .POLY(POLY)) u_lfsr (
    .i_clk   (clk_fpga),
    .i_rst   (reset),
    .o_state (w_lfsr)
  );

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= delivery;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_press = r_sync2 & ~r_prev;
  assign w_load  = (r_state == IDLE) && w_press && enable;
  assign w_hs    = (r_state == OFFER) && out_ready;
  assign w_ball  = decode(kind_of(w_lfsr[3:0]));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_press && enable) w_next = OFFER;
      OFFER:    if (out_ready)         w_next = COOLDOWN;
      COOLDOWN: if (r_cool <= 8'd1)    w_next = IDLE;
      default:                         w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cool  <= 8'd0;
      r_valid <= 1'b0;
      r_code  <= 4'd0;
      r_ball  <= '0;
      r_count <= 16'd0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_valid <= 1'b1;
        r_code  <= w_lfsr[3:0];
        r_ball  <= w_ball;
      end
      if (w_hs) begin
        r_valid <= 1'b0;
        r_cool  <= 8'(COOLDOWN_CYCLES);
        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
      end else if (r_state == COOLDOWN && r_cool != 8'd0) begin
        r_cool <= r_cool - 8'd1;
      end
    end
  end

  assign out_valid      = r_valid;
  assign outcome_code   = r_code;
  assign runs           = r_ball.runs;
  assign is_extra       = r_ball.is_extra;
  assign is_wicket      = r_ball.is_wicket;
  assign legal_ball     = r_ball.legal_ball;
  assign delivery_count = r_count;
  assign lfsr_state     = w_lfsr;

endmodule

// File: tb/tb_delivery_outcome_gen.sv
// Randomised and directed bench for delivery_outcome_gen, checked against a behavioural ball model.
module tb_delivery_outcome_gen;

  localparam int COOL = 4;

  logic        clk_fpga = 1'b0;
  logic        reset, delivery, enable, out_ready;
  logic        out_valid, is_extra, is_wicket, legal_ball;
  logic [3:0]  outcome_code;
  logic [2:0]  runs;
  logic [15:0] delivery_count, lfsr_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: the sampled button history, the ball on offer, and the cooldown left.
  logic [15:0] m_lfsr;
  logic [2:0]  m_hist;
  logic        m_offer;
  int          m_cool;
  logic [3:0]  m_code;
  int          m_cnt;
  int          runs_tbl [16] = '{0,0,0,1,1,1,1,2,2,2,3,4,6,1,1,0};

  delivery_outcome_gen #(.SEED(16'hACE1), .POLY(16'hB400), .COOLDOWN_CYCLES(COOL)) dut (
    .clk_fpga       (clk_fpga),
    .reset          (reset),
    .delivery       (delivery),
    .enable         (enable),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .outcome_code   (outcome_code),
    .runs           (runs),
    .is_extra       (is_extra),
    .is_wicket      (is_wicket),
    .legal_ball     (legal_ball),
    .delivery_count (delivery_count),
    .lfsr_state     (lfsr_state)
  );

  always #5 clk_fpga = ~clk_fpga;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lfsr  = 16'hACE1;
    m_hist  = 3'b000;
    m_offer = 1'b0;
    m_cool  = 0;
    m_code  = 4'd0;
    m_cnt   = 0;
  endtask

  task automatic model_edge();
    logic pressed;
    if (reset) begin
      model_reset();
      return;
    end
    pressed = m_hist[1] & ~m_hist[2];
    if (m_offer) begin
      if (out_ready) begin
        m_offer = 1'b0;
        m_cool  = COOL;
        if (m_cnt < 65535) m_cnt++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (pressed && enable) begin
      m_offer = 1'b1;
      m_code  = m_lfsr[3:0];
    end
    m_hist = {m_hist[1:0], delivery};
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  endtask

  task automatic check_all(input string ph);
    logic ex;
    ex = (m_code == 4'd13) || (m_code == 4'd14);
    chk({ph, ".valid"}, 32'(out_valid), 32'(m_offer));
    chk({ph, ".code"},  32'(outcome_code), 32'(m_code));
    chk({ph, ".runs"},  32'(runs), 32'(runs_tbl[m_code]));
    chk({ph, ".extra"}, 32'(is_extra), 32'(ex));
    chk({ph, ".wkt"},   32'(is_wicket), 32'(m_code == 4'd15));
    chk({ph, ".legal"}, 32'(legal_ball), 32'(!ex && (m_cnt > 0 || m_offer || m_code != 4'd0) ? 1'b1 : !ex));
    chk({ph, ".count"}, 32'(delivery_count), 32'(m_cnt));
    chk({ph, ".lfsr"},  32'(lfsr_state), 32'(m_lfsr));
  endtask

  // The reset value of legal_ball is 0, whereas the decode of code 0 would give 1.
  // The model therefore tracks whether any ball has been latched since reset.
  logic m_latched;

  task automatic step(input string ph);
    @(posedge clk_fpga);
    model_edge();
    if (reset) m_latched = 1'b0;
    else if (m_offer) m_latched = 1'b1;
    #1;
    chk({ph, ".valid"}, 32'(out_valid), 32'(m_offer));
    chk({ph, ".code"},  32'(outcome_code), 32'(m_code));
    chk({ph, ".runs"},  32'(runs), m_latched ? 32'(runs_tbl[m_code]) : 32'd0);
    chk({ph, ".extra"}, 32'(is_extra), 32'(m_latched && (m_code == 4'd13 || m_code == 4'd14)));
    chk({ph, ".wkt"},   32'(is_wicket), 32'(m_latched && m_code == 4'd15));
    chk({ph, ".legal"}, 32'(legal_ball), 32'(m_latched && m_code != 4'd13 && m_code != 4'd14));
    chk({ph, ".count"}, 32'(delivery_count), 32'(m_cnt));
    chk({ph, ".lfsr"},  32'(lfsr_state), 32'(m_lfsr));
    @(negedge clk_fpga);
  endtask

  task automatic async_reset_check(input string ph);
    reset = 1'b1;
    model_reset();
    m_latched = 1'b0;
    #1;
    chk({ph, ".valid"}, 32'(out_valid), 32'd0);
    chk({ph, ".lfsr"},  32'(lfsr_state), 32'hACE1);
    chk({ph, ".count"}, 32'(delivery_count), 32'd0);
    chk({ph, ".legal"}, 32'(legal_ball), 32'd0);
  endtask

  initial begin
    reset = 1'b1; delivery = 1'b0; enable = 1'b1; out_ready = 1'b0;
    model_reset();
    m_latched = 1'b0;
    #1;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.lfsr",  32'(lfsr_state), 32'hACE1);
    chk("rst.count", 32'(delivery_count), 32'd0);
    chk("rst.code",  32'(outcome_code), 32'd0);

    delivery = 1'b1;
    step("rst"); step("rst");
    reset = 1'b0;
    step("t1"); step("t1"); step("t1");
    chk("t1.valid_e3", 32'(out_valid), 32'd1);
    chk("t1.code8",    32'(outcome_code), 32'd8);
    chk("t1.runs2",    32'(runs), 32'd2);
    chk("t1.legal",    32'(legal_ball), 32'd1);
    step("t1");

    out_ready = 1'b1; step("t2");
    out_ready = 1'b0;
    chk("t2.valid_drop", 32'(out_valid), 32'd0);
    chk("t2.count1",     32'(delivery_count), 32'd1);
    delivery = 1'b0; step("t2");
    delivery = 1'b1;
    for (int i = 0; i < 6; i++) step("t2");
    chk("t2.cool_press_ignored", 32'(out_valid), 32'd0);
    delivery = 1'b0; step("t2"); step("t2");
    delivery = 1'b1; step("t2"); step("t2"); step("t2");
    chk("t2.press_after_cool", 32'(out_valid), 32'd1);

    out_ready = 1'b1; step("t3");
    out_ready = 1'b0;
    for (int i = 0; i < 50; i++) step("t3");
    chk("t3.no_second", 32'(out_valid), 32'd0);
    chk("t3.count2",    32'(delivery_count), 32'd2);

    delivery = 1'b0; step("t5"); step("t5");
    enable = 1'b0; delivery = 1'b1;
    for (int i = 0; i < 6; i++) step("t5");
    chk("t5.enable_blocks", 32'(out_valid), 32'd0);
    delivery = 1'b0; step("t5"); step("t5");
    enable = 1'b1; delivery = 1'b1; step("t5"); step("t5"); step("t5");
    chk("t5.accepted", 32'(out_valid), 32'd1);
    enable = 1'b0; step("t5"); step("t5");
    out_ready = 1'b1; step("t5");
    out_ready = 1'b0;
    chk("t5.count3", 32'(delivery_count), 32'd3);
    enable = 1'b1;
    for (int i = 0; i < 6; i++) step("t5");

    delivery = 1'b0; step("t6"); step("t6");
    delivery = 1'b1; step("t6"); step("t6"); step("t6");
    chk("t6.offer", 32'(out_valid), 32'd1);
    async_reset_check("t6.async");
    step("t6"); step("t6");
    reset = 1'b0;
    step("t6"); step("t6"); step("t6");
    chk("t6.code8_again", 32'(outcome_code), 32'd8);
    chk("t6.valid_again", 32'(out_valid), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) delivery = ~delivery;
      enable    = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 299) == 0) begin
        async_reset_check("rnd.async");
        step("rnd");
        reset = 1'b0;
      end
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/delivery_outcome_gen.md
Name: delivery_outcome_gen

Overview:
Producer side of the ball-outcome path in the cricket game. It synchronises the raw delivery button and free-runs a 16-bit LFSR. On each accepted press it latches the low nibble of the LFSR and decodes it into a ball result (runs / extra / wicket). The result is offered to the scoreboard over a valid/ready handshake, followed by a cooldown so that one press produces exactly one ball.

Parameters:
SEED, 16'hACE1, LFSR reset value; an all-zero SEED is replaced by 16'h0001.
POLY, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1).
COOLDOWN_CYCLES, 4, idle cycles after a handshake before presses are accepted again; legal range 1..255.

Ports:
clk_fpga  in  1  system clock; sole clock.
reset  in  1  asynchronous, active-high; all state to reset values.
delivery  in  1  raw bowl button, asynchronous to clk_fpga.
enable  in  1  high while an innings is live; low blocks new presses.
out_ready  in  1  scoreboard accepts the offered result.
out_valid  out  1  result offered.
outcome_code  out  4  latched LFSR nibble (0..15).
runs  out  3  runs credited (0,1,2,3,4,6).
is_extra  out  1  wide or no-ball.
is_wicket  out  1  wicket.
legal_ball  out  1  ball counts toward the over.
delivery_count  out  16  handshakes completed; saturates at 16'hFFFF.
lfsr_state  out  16  current LFSR value, for debug.

Behaviour:
- Clock and reset: one clock, clk_fpga; reset is asynchronous and active-high.
- Reset values:
  - lfsr_state = SEED.
  - out_valid = 0; outcome_code, runs, is_extra, is_wicket, legal_ball = 0.
  - delivery_count = 0.
  - FSM = IDLE; both sync flops and the edge-history flop = 0.
- LFSR:
  - Advances every clock, in every state: next = (lfsr>>1) ^ (lfsr[0] ? POLY : 0).
  - Never reaches zero.
  - From SEED 16'hACE1 the sequence after reset is ACE1, E270, 7138, 389C, 1C4E, 0E27.
- Input path:
  - 2-flop synchroniser sync1 -> sync2, then prev <= sync2.
  - press = sync2 & ~prev, a single-cycle pulse.
- FSM states and transitions:
  - IDLE: if press & enable, latch lfsr_state[3:0] into outcome_code, register the decoded fields, set out_valid=1, go to OFFER. Otherwise stay in IDLE.
  - OFFER: out_valid held high and all outputs stable until an edge with out_ready=1. On that edge: out_valid<=0, increment delivery_count (saturating), load the cooldown counter with COOLDOWN_CYCLES, go to COOLDOWN. Ready may already be high on the first cycle of OFFER, so the handshake can complete in that cycle.
  - COOLDOWN: decrement the counter each cycle; when it reaches 0, return to IDLE. The result fields keep their last values.
- Nibble decode (registered together with outcome_code):
  - 0-2: dot, runs 0.
  - 3-6: single, runs 1.
  - 7-9: double, runs 2.
  - 10: triple, runs 3.
  - 11: four, runs 4.
  - 12: six, runs 6.
  - 13: wide, runs 1, is_extra=1, legal_ball=0.
  - 14: no-ball, runs 1, is_extra=1, legal_ball=0.
  - 15: wicket, runs 0, is_wicket=1.
  - legal_ball=1 for every code except 13 and 14.
- Latency: delivery is first sampled high at edge e1; the result is latched at e3, so out_valid is high after e3. The outcome uses the LFSR value present just before e3.
- Boundary conditions:
  - Button held high: one press only; the button must be released and pressed again for another ball.
  - Press during OFFER or COOLDOWN: discarded, not queued.
  - Press and return to IDLE in the same cycle: discarded.
  - enable low: no effect on an in-flight OFFER or COOLDOWN; only blocks acceptance in IDLE.
  - Reset mid-OFFER: out_valid drops immediately (asynchronously), no count increment, LFSR reloads SEED.

Decomposition:
- Shared package cricket_pkg holds:
  - outcome kind enum: DOT, SINGLE, DOUBLE, TRIPLE, FOUR, SIX, WIDE, NOBALL, WICKET;
  - nibble range constants;
  - POLY and SEED defaults;
  - FSM state enum: IDLE, OFFER, COOLDOWN.
- One sub-module, cg_lfsr16: parameterised SEED and POLY, async reset, free-running, exposes state.

Test Plan:
1. Reset, then hold delivery=1 from reset release with enable=1 and out_ready=0 -> after e3 out_valid=1, outcome_code=8, runs=2, legal_ball=1, lfsr_state=7138 at the latch edge.
2. Continue case 1, raise out_ready for one cycle -> out_valid=0 next edge, delivery_count=1. A new press 2 cycles later is ignored; a press after 4 cooldown cycles plus release is accepted.
3. Keep delivery high for 50 cycles after a completed handshake -> no second out_valid, delivery_count stays 1.
4. Force the latched nibble (or sweep presses against the reference model) through all 16 codes -> codes 13 and 14 give is_extra=1, legal_ball=0, runs=1; code 15 gives is_wicket=1, runs=0; code 12 gives runs=6.
5. enable=0 with a press in IDLE -> no out_valid. A press accepted, then enable=0 during OFFER -> handshake still completes and the count increments.
6. Assert reset mid-OFFER -> out_valid=0 without a clock edge, lfsr_state=ACE1, delivery_count=0; the next press again yields outcome_code 8 under case 1 timing.
